// File: rtl/dgiota_uio_tx.sv
// dgiota_uio_tx: byte-wide FIFO feeding an 8N1 serial transmitter on uio[0].
// Bytes on ui_in are queued by rising edges of the uio_in[0] strobe; status on uo_out.
// Optional build macro DGIOTA_TX_PARITY_EN inserts an even-parity bit after the data bits.
module dgiota_uio_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

`ifdef DGIOTA_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            txd_q;

  logic [1:0]      strb_sync_q;
  logic [1:0]      clr_sync_q;
  logic            strb_prev_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            ovf_q;

  logic push, pop, wr_en, ovf_set, ovf_clr;
  logic full, empty, busy, baud_last;
  logic [7:0] rd_data;
  logic [3:0] count_ext;
  logic unused_bits;

  // Two-flop synchronizers for the asynchronous strobe and clear, plus edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync_q <= '0;
      clr_sync_q  <= '0;
      strb_prev_q <= 1'b0;
    end else begin
      strb_sync_q <= {strb_sync_q[0], uio_in[0]};
      clr_sync_q  <= {clr_sync_q[0], uio_in[1]};
      strb_prev_q <= strb_sync_q[1];
    end
  end

  // FIFO control and push/pop/overflow decode
  always_comb begin
    push      = strb_sync_q[1] & ~strb_prev_q;
    ovf_clr   = clr_sync_q[1];
    full      = (count_q == CountFull);
    empty     = (count_q == '0);
    busy      = (state_q != StIdle);
    pop       = (state_q == StIdle) & ~empty & ena;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle
    wr_en     = push & (~full | pop);
    ovf_set   = push & full & ~pop;
    rd_data   = mem_q[rd_ptr_q];
    baud_last = (baud_q == BaudLast);
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ui_in;
  end

  // FIFO pointers, occupancy and sticky overflow (clear beats a same-cycle set)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_clr)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Transmit FSM; txd is registered from the current state so the line follows
  // the state by one clock and never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= rd_data;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          txd_q <= 1'b0;
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StData: begin
          txd_q <= shift_q[bit_idx_q];
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef DGIOTA_TX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
`ifdef DGIOTA_TX_PARITY_EN
        StParity: begin
          txd_q <= ^shift_q;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
`endif
        StStop: begin
          txd_q <= 1'b1;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          baud_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status and pad outputs
  always_comb begin
    count_ext   = 4'(count_q);
    uo_out      = {1'b0, count_ext[2:0], ovf_q, empty, full, busy};
    uio_out     = {7'b000_0000, txd_q};
    uio_oe      = 8'b0000_0001;
    unused_bits = ^{uio_in[7:2], count_ext[3]};
  end

endmodule

// File: tb/tb_dgiota_uio_tx.sv
// Self-checking bench for dgiota_uio_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes every frame on txd and compares it with a byte queue model.
`timescale 1ns/1ps
module tb_dgiota_uio_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef DGIOTA_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  dgiota_uio_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: bytes accepted but not yet started on the line, plus overflow flag
  logic [7:0] exp_q[$];
  bit         model_ovf = 1'b0;
  int         start_q[$];
  int         frames_seen = 0;
  int         last_push_cyc = 0;
  int         prev_cnt = 0;

  logic [FRAME_BITS-1:0] mon_bits;
  bit                    mon_shape;
  bit                    mon_abort;
  bit                    mon_has_exp;
  logic [7:0]            mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Note the cycle in which the FIFO count rises (the push cycle)
  initial begin : push_watch
    forever begin
      @(negedge clk);
      if (int'(uo_out[6:4]) > prev_cnt) last_push_cyc = cyc;
      prev_cnt = int'(uo_out[6:4]);
    end
  end

  // Line monitor: decode each frame sample-by-sample
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && uio_out[0] == 1'b0) begin
        start_q.push_back(cyc);
        mon_has_exp = (exp_q.size() != 0);
        if (mon_has_exp) mon_exp = exp_q.pop_front();
        mon_shape = 1'b1;
        mon_abort = 1'b0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
          if (i != 0) @(negedge clk);
          if (!rst_n) begin
            mon_abort = 1'b1;
            break;
          end
          if (i % CPB == 0) mon_bits[i / CPB] = uio_out[0];
          else if (uio_out[0] !== mon_bits[i / CPB]) mon_shape = 1'b0;
        end
        if (!mon_abort) begin
          frames_seen++;
          check("frame_expected", 32'(mon_has_exp), 32'd1);
          check("bit_width", 32'(mon_shape), 32'd1);
          if (mon_has_exp) check("frame_data", 32'(mon_bits[8:1]), 32'(mon_exp));
`ifdef DGIOTA_TX_PARITY_EN
          if (mon_has_exp) check("parity_bit", 32'(mon_bits[9]), 32'(^mon_exp));
`endif
          check("stop_bit", 32'(mon_bits[FRAME_BITS-1]), 32'd1);
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else model_ovf = 1'b1;
    ui_in     = b;
    uio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_ovf();
    uio_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    uio_in[1] = 1'b0;
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(uo_out[0] == 1'b0 && uo_out[2] == 1'b1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n = 0;
    while (start_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : main
    int s0;
    int fs;
    int nb;
    logic [7:0] rb;

    // Reset values, asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_uo_out", 32'(uo_out), 32'h04);
    check("rst_uio_out", 32'(uio_out), 32'h01);
    check("rst_uio_oe", 32'(uio_oe), 32'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: waveform and push-to-start latency
    s0 = start_q.size();
    push(8'hA5);
    wait_idle("a5", 200);
    check("a5_frames", 32'(start_q.size() - s0), 32'd1);
    if (start_q.size() > s0) check("latency", 32'(start_q[s0] - last_push_cyc), 32'd2);

    // Three rapid pushes: back-to-back frames with one idle cycle between
    s0 = start_q.size();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_starts("burst3", s0 + 3, 400);
    check("empty_after_last", 32'(uo_out[2]), 32'd1);
    wait_idle("burst3", 400);
    if (start_q.size() >= s0 + 3) begin
      check("gap_1_2", 32'(start_q[s0+1] - start_q[s0]), 32'(FRAME_CLKS + 1));
      check("gap_2_3", 32'(start_q[s0+2] - start_q[s0+1]), 32'(FRAME_CLKS + 1));
    end

    // Overflow with ena low: fifth byte dropped, sticky flag until cleared
    ena = 1'b0;
    fs  = frames_seen;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    check("ovf_full", 32'(uo_out[1]), 32'(exp_q.size() == DEPTH));
    check("ovf_count", 32'(uo_out[6:4]), 32'(exp_q.size()));
    check("ovf_flag", 32'(uo_out[3]), 32'(model_ovf));
    check("ovf_busy", 32'(uo_out[0]), 32'd0);
    repeat (10) @(negedge clk);
    check("ovf_sticky", 32'(uo_out[3]), 32'(model_ovf));
    clear_ovf();
    check("ovf_cleared", 32'(uo_out[3]), 32'(model_ovf));
    ena = 1'b1;
    wait_idle("drain4", 600);
    check("drain4_frames", 32'(frames_seen - fs), 32'd4);

    // ena dropped mid-frame: current frame completes, queued byte is held
    fs = frames_seen;
    push(8'h81);
    ena = 1'b0;
    check("ena_busy", 32'(uo_out[0]), 32'd1);
    push(8'h42);
    repeat (3 * FRAME_CLKS) @(negedge clk);
    check("ena_one_frame", 32'(frames_seen - fs), 32'd1);
    check("ena_held_count", 32'(uo_out[6:4]), 32'(exp_q.size()));
    check("ena_idle", 32'(uo_out[0]), 32'd0);
    ena = 1'b1;
    wait_idle("ena_resume", 300);
    check("ena_two_frames", 32'(frames_seen - fs), 32'd2);

    // Reset during data bit 3: line high at once, queued byte lost
    s0 = start_q.size();
    push(8'hC3);
    push(8'h9A);
    wait_starts("rst_mid", s0 + 1, 200);
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_txd", 32'(uio_out[0]), 32'd1);
    check("rst_mid_uo", 32'(uo_out), 32'h04);
    exp_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fs = frames_seen;
    repeat (2 * FRAME_CLKS) @(negedge clk);
    check("rst_no_frame", 32'(frames_seen - fs), 32'd0);
    push(8'h55);
    wait_idle("post_rst", 200);
    check("post_rst_frames", 32'(frames_seen - fs), 32'd1);

    // Parity corner bytes
    push(8'h01);
    push(8'h03);
    wait_idle("par", 300);

    // Randomized bursts of up to three bytes with random spacing
    for (int it = 0; it < 15; it++) begin
      fs = frames_seen;
      nb = int'($urandom_range(1, 3));
      for (int k = 0; k < nb; k++) begin
        rb = 8'($urandom);
        push(rb);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_idle("rand", 600);
      check("rand_frames", 32'(frames_seen - fs), 32'(nb));
    end
    check("final_ovf", 32'(uo_out[3]), 32'(model_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dgiota_uio_tx.md
DGIOTA_UIO_TX -- requirements
Module: dgiota_uio_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clocks per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..8.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  design enable; low blocks new frame starts.
REQ-006 ui_in  input  8  byte to enqueue.
REQ-007 uio_in  input  8  [0] write strobe, asynchronous; [1] overflow clear, asynchronous; [7:2] unused.
REQ-008 uo_out  output  8  status: [0] busy, [1] full, [2] empty, [3] overflow sticky, [6:4] FIFO count, [7] 0.
REQ-009 uio_out  output  8  [0] txd serial line; [7:1] constant 0.
REQ-010 uio_oe  output  8  constant 8'b0000_0001; only uio[0] is driven.

Function
REQ-011 uio_in[0] and uio_in[1] SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A rising edge of synchronized strobe SHALL push ui_in, sampled in the detection cycle, into the FIFO.
REQ-013 Push while full and no same-cycle pop SHALL discard the byte and set overflow; FIFO contents unchanged.
REQ-014 Push and pop in the same cycle SHALL both occur; count unchanged; accepted even when full.
REQ-015 Overflow SHALL stay set until synchronized uio_in[1] is high; clear wins over a same-cycle set.
REQ-016 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE: txd=1; when FIFO non-empty and ena=1, pop head into shift register and go to START next cycle.
REQ-018 START: txd=0 for CLKS_PER_BIT clocks, then DATA.
REQ-019 DATA: 8 bits LSB first, each CLKS_PER_BIT clocks; 3-bit index wraps 7->0 on exit to PARITY or STOP.
REQ-020 STOP: txd=1 for CLKS_PER_BIT clocks, then IDLE; back-to-back frames SHALL add no idle cycle beyond the one IDLE pop cycle.
REQ-021 Latency: txd SHALL fall exactly 2 clocks after the push cycle when FIFO was empty and FSM idle.
REQ-022 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reload 0 on every state change.
REQ-023 ena falling mid-frame SHALL let the current frame finish; no new pop while ena=0.
REQ-024 busy=1 in every state except IDLE; full/empty/count SHALL reflect registered FIFO state.
REQ-025 txd SHALL be driven from a flop (glitch-free).

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, txd=1, FIFO empty (count 0), pointers 0, overflow 0, synchronizers 0, baud counter 0.
REQ-027 Reset mid-frame SHALL abort the frame; txd returns to 1 asynchronously; queued bytes are lost.
REQ-028 Reset values: uo_out=8'b0000_0100, uio_out=8'b0000_0001, uio_oe=8'b0000_0001.

Configuration
REQ-029 Macro DGIOTA_TX_PARITY_EN defined: PARITY state inserted after DATA, txd = even parity (XOR of 8 data bits) for CLKS_PER_BIT clocks; frame = 11 bits.
REQ-030 Macro undefined: no PARITY state or logic; DATA goes directly to STOP; frame = 10 bits.

Verification
REQ-031 CLKS_PER_BIT=4, push 0xA5 -> txd: 0 for 4 clk, then 1,0,1,0,0,1,0,1 (4 clk each), [parity 0 if enabled], 1 stop; falls 2 clk after push.
REQ-032 Push 0x00,0xFF,0x3C rapidly -> three contiguous frames in order, one idle cycle between stop and next start, empty=1 after last pop.
REQ-033 FIFO_DEPTH=4, ena=0, push 5 bytes -> full=1, count=4, overflow=1, 5th byte never sent; pulse uio_in[1] -> overflow=0.
REQ-034 ena=0 mid-frame 0x81 -> frame completes intact; next queued byte held until ena=1.
REQ-035 rst_n low during DATA bit 3 -> txd=1 same cycle, uo_out=0x04; after release, push 0x55 -> correct frame.
REQ-036 Parity build, push 0x01 -> parity bit 1; push 0x03 -> parity bit 0; non-parity build frame length 10*CLKS_PER_BIT.
